// File: rtl/div_ctrl_pkg.sv
// Shared types and constants for the divider sequencing controller.
package div_ctrl_pkg;

  localparam int DATA_W          = 32;
  localparam int DIV_TIMEOUT_DEF = 40;

  typedef enum logic [1:0] {
    DivCtrlIdle  = 2'd0,
    DivCtrlRun   = 2'd1,
    DivCtrlDone  = 2'd2,
    DivCtrlAbort = 2'd3
  } div_ctrl_state_e;

endpackage

// File: rtl/div_ctrl.sv
// Sequences the multi-cycle radix-2 divider for DIV/DIVU in EX: start/annul/sign
// control, pipeline stall, timeout detection and the one-cycle HI/LO write request.
module div_ctrl
  import div_ctrl_pkg::*;
#(
  parameter int unsigned TIMEOUT = DIV_TIMEOUT_DEF
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                div_req_i,
  input  logic                div_signed_i,
  input  logic [DATA_W-1:0]   div_op1_i,
  input  logic [DATA_W-1:0]   div_op2_i,
  input  logic                flush_i,
  input  logic                hold_i,
  output logic                stall_o,
  output logic                hilo_we_o,
  output logic [DATA_W-1:0]   hi_o,
  output logic [DATA_W-1:0]   lo_o,
  output logic                div_start_o,
  output logic                div_annul_o,
  output logic                div_signed_o,
  output logic [DATA_W-1:0]   div_opdata1_o,
  output logic [DATA_W-1:0]   div_opdata2_o,
  input  logic [2*DATA_W-1:0] div_result_i,
  input  logic                div_ready_i,
  output logic                div_err_o
);

  localparam int TMO_W = $clog2(TIMEOUT + 1);

  div_ctrl_state_e  state;
  logic [TMO_W-1:0] tmo_cnt;
  logic             abort_cnt;

  // DONE drops the stall so the instruction retires together with the strobe.
  assign stall_o   = div_req_i && (state != DivCtrlDone) && !flush_i;
  assign hilo_we_o = (state == DivCtrlDone) && !hold_i && !flush_i;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state         <= DivCtrlIdle;
      tmo_cnt       <= '0;
      abort_cnt     <= 1'b0;
      hi_o          <= '0;
      lo_o          <= '0;
      div_start_o   <= 1'b0;
      div_annul_o   <= 1'b0;
      div_signed_o  <= 1'b0;
      div_opdata1_o <= '0;
      div_opdata2_o <= '0;
      div_err_o     <= 1'b0;
    end else begin
      div_err_o <= 1'b0;
      case (state)
        DivCtrlIdle: begin
          if (div_req_i && !flush_i) begin
            div_opdata1_o <= div_op1_i;
            div_opdata2_o <= div_op2_i;
            div_signed_o  <= div_signed_i;
            tmo_cnt       <= '0;
            div_start_o   <= 1'b1;
            state         <= DivCtrlRun;
          end
        end
        DivCtrlRun: begin
          // Operands stay latched: the divider re-reads them for sign fixup.
          if (flush_i) begin
            div_start_o <= 1'b0;
            div_annul_o <= 1'b1;
            abort_cnt   <= 1'b0;
            state       <= DivCtrlAbort;
          end else if (div_ready_i) begin
            hi_o        <= div_result_i[2*DATA_W-1:DATA_W];
            lo_o        <= div_result_i[DATA_W-1:0];
            div_start_o <= 1'b0;
            state       <= DivCtrlDone;
          end else if (tmo_cnt == TMO_W'(TIMEOUT - 1)) begin
            div_err_o   <= 1'b1;
            div_start_o <= 1'b0;
            div_annul_o <= 1'b1;
            abort_cnt   <= 1'b0;
            state       <= DivCtrlAbort;
          end else begin
            tmo_cnt <= tmo_cnt + TMO_W'(1);
          end
        end
        DivCtrlDone: begin
          if (!hold_i || flush_i) begin
            state <= DivCtrlIdle;
          end
        end
        DivCtrlAbort: begin
          // Two annul cycles clear the divider from its on, by-zero or end state.
          if (abort_cnt) begin
            div_annul_o <= 1'b0;
            state       <= DivCtrlIdle;
          end else begin
            abort_cnt <= 1'b1;
          end
        end
        default: begin
          div_start_o <= 1'b0;
          div_annul_o <= 1'b0;
          state       <= DivCtrlIdle;
        end
      endcase
    end
  end

endmodule
